// File: rtl/spi_mem_param_if.sv
// Serial memory port: controller-driven select/data in, memory-driven data out and status.
interface spi_mem_param_if;
    logic cs;
    logic miso;
    logic mosi;
    logic ready;
    logic op_done;
    logic err;

    modport master (output cs, miso, input mosi, ready, op_done, err);
    modport slave  (input cs, miso, output mosi, ready, op_done, err);
endinterface

// File: rtl/spi_mem_param.sv
// Bit-serial word memory: op bit, LSB-first address, then burst write or burst read.
//
// state | meaning
// IDLE  | waiting for cs low
// OP    | sampling the read/write op bit
// ADDR  | shifting in the address, LSB first
// WR    | shifting in write words, burst with wrapping address
// FETCH | loading the next read word, pulsing ready
// SEND  | shifting the read word out on mosi, then op_done
module spi_mem_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    spi_mem_param_if.slave  bus
);
    generate
        if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("spi_mem_param: DEPTH must lie in 2..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, OP, ADDR, WR, FETCH, SEND} state_t;

    localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);

    state_t              state, state_nxt;
    logic                is_wr, is_wr_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic                mosi_q, mosi_nxt;
    logic                ready_q, ready_nxt;
    logic                op_done_q, op_done_nxt;
    logic                err_q, err_nxt;
    logic                mem_we;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic [ADDR_W-1:0]   addr_asm;
    logic [DATA_W-1:0]   data_asm;
    logic [ADDR_W-1:0]   addr_inc;
    logic [DATA_W-1:0]   mem_rd;

    assign addr_asm = addr | (ADDR_W'(bus.miso) << cnt);
    assign data_asm = shreg | (DATA_W'(bus.miso) << cnt);
    assign addr_inc = (addr == ADDR_TOP) ? '0 : addr + 1'b1;
    assign mem_rd   = mem[addr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            is_wr     <= 1'b0;
            addr      <= '0;
            cnt       <= '0;
            shreg     <= '0;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b0;
            op_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            is_wr     <= is_wr_nxt;
            addr      <= addr_nxt;
            cnt       <= cnt_nxt;
            shreg     <= shreg_nxt;
            mosi_q    <= mosi_nxt;
            ready_q   <= ready_nxt;
            op_done_q <= op_done_nxt;
            err_q     <= err_nxt;
        end
    end

    // Memory is deliberately left out of reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[addr[IDX_W-1:0]] <= data_asm;
        end
    end

    always_comb begin
        state_nxt   = state;
        is_wr_nxt   = is_wr;
        addr_nxt    = addr;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        mosi_nxt    = 1'b0;
        ready_nxt   = 1'b0;
        op_done_nxt = 1'b0;
        err_nxt     = err_q;
        mem_we      = 1'b0;
        if (bus.cs) begin
            // Frame end wins over everything, including a completing write word.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = OP;
                    cnt_nxt   = '0;
                    addr_nxt  = '0;
                    err_nxt   = 1'b0;
                end
                OP: begin
                    is_wr_nxt = bus.miso;
                    cnt_nxt   = '0;
                    state_nxt = ADDR;
                end
                ADDR: begin
                    addr_nxt = addr_asm;
                    if (cnt == ADDR_LAST) begin
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                        err_nxt   = ({1'b0, addr_asm} >= DEPTH_V);
                        state_nxt = is_wr ? WR : FETCH;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WR: begin
                    shreg_nxt = data_asm;
                    if (cnt == DATA_LAST) begin
                        mem_we      = !err_q;
                        op_done_nxt = 1'b1;
                        addr_nxt    = addr_inc;
                        cnt_nxt     = '0;
                        shreg_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                FETCH: begin
                    shreg_nxt = err_q ? '0 : mem_rd;
                    ready_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
                SEND: begin
                    if (cnt == DATA_END) begin
                        op_done_nxt = 1'b1;
                        addr_nxt    = addr_inc;
                        cnt_nxt     = '0;
                        state_nxt   = FETCH;
                    end else begin
                        mosi_nxt  = shreg[0];
                        shreg_nxt = shreg >> 1;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.mosi    = mosi_q;
    assign bus.ready   = ready_q;
    assign bus.op_done = op_done_q;
    assign bus.err     = err_q;
endmodule
